// File: rtl/t03_nes_pad_emulator_pkg.sv
// Shared NES pad definitions: FSM states, button bit positions and frame length.
// Imported by both the pad emulator and the controller reader.
package t03_nes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } nes_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int NES_BITS = 8;

endpackage

// File: rtl/t03_nes_pad_emulator_if.sv
// Serial pad bus between the controller reader (master) and a pad (slave).
// No valid/ready handshake here: latch and pulse are level strobes owned by the
// master, and data_p* is a level the master samples once per pulse.
interface t03_nes_pad_emulator_if;
  logic latch;
  logic pulse;
  logic data_p1;
  logic data_p2;

  modport master (output latch, output pulse, input data_p1, input data_p2);
  modport slave  (input latch, input pulse, output data_p1, output data_p2);
endinterface

// File: rtl/t03_nes_pad_emulator_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by an edge
// register that yields one-cycle rise/fall strobes in the clk domain.
module t03_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/t03_nes_pad_emulator.sv
// Two-player 4021-style NES pad emulator answering the reader's latch/pulse
// sequence from push-button inputs; data lines are active-low.
module t03_nes_pad_emulator
  import t03_nes_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  t03_nes_pad_emulator_if.slave bus,
  input  logic [7:0]           buttons_p1,
  input  logic [7:0]           buttons_p2,
  output logic [3:0]           bit_count,
  output logic                 busy,
  output logic                 frame_done,
  output nes_state_e           state_dbg
);

  logic latch_rise, latch_fall;
  logic pulse_rise, pulse_fall;

  t03_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.latch),
    .rise (latch_rise),
    .fall (latch_fall)
  );

  t03_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.pulse),
    .rise (pulse_rise),
    .fall (pulse_fall)
  );

  nes_state_e state;
  logic [7:0] sr_p1, sr_p2;
  logic       data_p1_q, data_p2_q;
  logic [3:0] cnt_q;
  logic       frame_done_q;
  logic       unused_pulse_fall;

  assign unused_pulse_fall = pulse_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sr_p1        <= '0;
      sr_p2        <= '0;
      data_p1_q    <= 1'b1;
      data_p2_q    <= 1'b1;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          data_p1_q <= 1'b1;
          data_p2_q <= 1'b1;
          cnt_q     <= '0;
          if (latch_rise) state <= ST_LOAD;
        end
        // Loads every cycle so the frame holds whatever was present at latch fall.
        ST_LOAD: begin
          sr_p1     <= buttons_p1;
          sr_p2     <= buttons_p2;
          data_p1_q <= ~buttons_p1[BTN_A];
          data_p2_q <= ~buttons_p2[BTN_A];
          cnt_q     <= '0;
          if (latch_fall) state <= ST_SHIFT;
        end
        // Latch takes priority over a coincident pulse: abort and reload.
        ST_SHIFT: begin
          if (latch_rise) begin
            state <= ST_LOAD;
            cnt_q <= '0;
          end else if (pulse_rise) begin
            sr_p1 <= sr_p1 >> 1;
            sr_p2 <= sr_p2 >> 1;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(NES_BITS - 1)) begin
              state        <= ST_DONE;
              frame_done_q <= 1'b1;
              data_p1_q    <= 1'b1;
              data_p2_q    <= 1'b1;
            end else begin
              data_p1_q <= ~sr_p1[1];
              data_p2_q <= ~sr_p2[1];
            end
          end
        end
        ST_DONE: begin
          data_p1_q <= 1'b1;
          data_p2_q <= 1'b1;
          if (latch_rise) begin
            state <= ST_LOAD;
            cnt_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_p1 = data_p1_q;
  assign bus.data_p2 = data_p2_q;
  assign bit_count   = cnt_q;
  assign busy        = (state == ST_LOAD) || (state == ST_SHIFT);
  assign frame_done  = frame_done_q;
  assign state_dbg   = state;

endmodule

// File: doc/t03_nes_pad_emulator.md
# t03_nes_pad_emulator

Controller-side end of the NES controller serial protocol: emulates two 4021-style pad shift registers driven by FPGA push-button inputs, answering the latch/pulse sequence issued by the team's NES controller reader. It lets the reader and MMIO path run on the ice40 board without physical pads, and serves as the pad model in reader testbenches. It sits between the `pb` button bank and the reader's latch, pulse and data lines.

## Interface
- `SYNC_STAGES`, 2, flip-flop depth of the latch/pulse synchronizers (≥2)
- `clk` input 1: system clock (10 MHz on board)
- `rst` input 1: asynchronous, active-high reset
- `latch` input 1: reader latch line, active-high, asynchronous to `clk`
- `pulse` input 1: reader clock line, active-high, asynchronous to `clk`
- `buttons_p1` input 8: player 1 buttons, 1 = pressed; bit order A, B, Select, Start, Up, Down, Left, Right (bit 0 = A)
- `buttons_p2` input 8: player 2 buttons, same order
- `data_p1` output 1: player 1 serial data, active-low (0 = pressed)
- `data_p2` output 1: player 2 serial data, active-low
- `bit_count` output 4: bits shifted since the last latch release, 0..8
- `busy` output 1: high while a frame is loading or shifting
- `frame_done` output 1: one-cycle strobe when the 8th shift completes

## Operation
- `latch` and `pulse` each pass through a `SYNC_STAGES`-deep synchronizer plus one edge-detect register. The rising and falling edges of the synchronized signals drive the FSM.
- The FSM has four states: IDLE, LOAD, SHIFT, DONE. Reset enters IDLE.
- IDLE: `data_p*` = 1 and `bit_count` = 0. A synchronized latch rise moves to LOAD.
- LOAD: the shift registers parallel-load `buttons_p*` every cycle, and `bit_count` = 0. Pulse edges are ignored. A latch fall moves to SHIFT; the registers hold the value loaded in the last LOAD cycle.
- SHIFT: `data_p*` = ~`sr_p*`[0]. Each synchronized pulse rise shifts both registers right, fills 0 (not pressed), and increments `bit_count`. The shift that makes `bit_count` = 8 asserts `frame_done` for one cycle and moves to DONE.
- DONE: `data_p*` = 1 and `bit_count` holds at 8. Further pulses are ignored, and `bit_count` saturates.
- A latch rise in SHIFT or DONE moves immediately to LOAD and aborts the current frame. No `frame_done` is issued for an aborted frame.
- If a latch rise and a pulse rise occur in the same cycle, the latch wins: the FSM goes to LOAD and no shift happens.
- Button inputs are sampled only in LOAD. Changes during SHIFT do not affect the current frame.
- `busy` = (state is LOAD or SHIFT).

## Timing
- Reset values: `data_p1` = `data_p2` = 1, `bit_count` = 0, `busy` = 0, `frame_done` = 0. All internal registers are cleared, and the synchronizers reset to 0.
- Input-to-action latency: a latch or pulse edge at the pin acts SYNC_STAGES+1 `clk` rising edges later. With the default depth that is 3 cycles (300 ns at 10 MHz).
- `data_p*` is registered. Bit k appears 1 cycle after the shift (or latch fall) that exposes it, and it stays stable until the next pulse acts.
- Each high phase and each low phase of `latch` and `pulse` must last at least SYNC_STAGES+1 cycles. Shorter glitches may be missed; this is not an error condition.
- The reader's standard timing (12 µs latch, 6 µs pulse phases, i.e. 120/60 cycles) meets this with a wide margin.
- The reader samples data 1 sample per pulse. The data line settles at most 4 cycles after a pulse rise, well inside a 60-cycle pulse-high phase.
- `rst` asserted mid-frame forces the reset values asynchronously. After release the block is in IDLE and needs a fresh latch.

## Structure
- Package `t03_nes_pkg` holds:
  - the FSM state enum (IDLE, LOAD, SHIFT, DONE)
  - the button index constants BTN_A=0 … BTN_RIGHT=7
  - the constant `NES_BITS` = 8
- The reader module also imports this package.
- Sub-module `t03_sync_edge` (a parameterized synchronizer with rise/fall strobes) is instantiated once for `latch` and once for `pulse`.
- The shift registers, counter and FSM live in the top of this block.

## Test plan
- After reset, check `data_p1` = `data_p2` = 1 and `bit_count` = 0. With `buttons_p1` = 8'h01 and `buttons_p2` = 8'h00, run a standard latch plus 8 pulses. Expect `data_p1` = 0,1,1,1,1,1,1,1 and `data_p2` = all 1s. Expect `frame_done` high for exactly 1 cycle, then DONE.
- With `buttons_p1` = 8'hA5 and `buttons_p2` = 8'h3C, run a full frame. Expect the sampled serial words, re-inverted, to equal 8'hA5 and 8'h3C.
- Change `buttons_p1` from 8'hFF to 8'h00 after the latch fall. Expect the frame to still read 8'hFF.
- Apply 10 pulses. Expect pulses 9 and 10 to leave `data_p*` = 1, `bit_count` = 8, and no second `frame_done`.
- Raise the latch after 3 shifts. Expect LOAD, `bit_count` = 0, no `frame_done`, and the next frame to read the current buttons correctly.
- Assert `rst` during a SHIFT at bit 5. Expect all outputs at reset values asynchronously, and pulses after release to be ignored until a latch.
